uns_add_256_ctrl: RTL and testbench
===================================

# uns_add_256_ctrl

Sequencing controller for the `UNS_ADD_256` word-serial 256-bit unsigned adder. It accepts operands A and B as sixteen 16-bit words over a valid/ready input stream, then drives the adder's register-enable, select and clear controls through load, carry-clear, compute and readout phases. It returns the 256-bit sum as sixteen words over a valid/ready output stream, together with the final carry. It replaces hand-driven control sequencing and sits between the host bus and the adder instance.

## Interface
- No parameters; word width is fixed at 16 and the word count at 16.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: begin an operation; sampled only in IDLE.
- `abort` in 1: synchronous; forces a return to IDLE at the next edge from any state.
- `in_valid` in 1 / `in_ready` out 1 / `in_data` in 16: operand stream, LSW first, A words 0..15 then B words 0..15.
- `out_valid` out 1 / `out_ready` in 1 / `out_data` out 16 / `out_last` out 1: sum stream, LSW first; `out_last` is high on word 15.
- `out_carry` out 1: final carry of A+B, registered.
- `busy` out 1: high when not in IDLE.
- `done` out 1: one-cycle pulse after the last sum word is accepted.
- `add_datain` out 16: drives adder `datain`; equals `in_data`.
- `rega_we`, `regb_we`, `dff_we`, `clr`, `regs_we` out 1 each: adder enables and carry clear.
- `rega_sel_cyc`, `regb_sel_cyc`, `regs_sel_cyc` out 1 each: adder select; 0 shifts in new data, 1 recirculates.
- `add_sum` in 16 / `add_carry` in 1: adder `sum` and `carry` outputs.

## Operation
- FSM states:
  - IDLE
  - LOAD_A
  - LOAD_B
  - CLR
  - COMP
  - READ
- A 4-bit word counter `cnt` runs alongside the FSM. It is zeroed on every state entry.
- IDLE:
  - All adder controls are 0 and `in_ready`=0.
  - When `start`=1, go to LOAD_A.
- LOAD_A:
  - `in_ready`=1 and `rega_sel_cyc`=0.
  - `rega_we` = `in_valid`.
  - Each accepted word increments `cnt`. After the word accepted at `cnt`=15, go to LOAD_B.
  - Cycles with `in_valid`=0 stall without shifting.
- LOAD_B: same as LOAD_A, but using `regb_we` and `regb_sel_cyc`=0. After word 15, go to CLR.
- CLR:
  - Lasts one cycle with `clr`=1, which zeroes the adder carry flip-flop.
  - All other enables are 0. Go to COMP.
- COMP:
  - Lasts exactly 16 cycles, with no handshake dependence.
  - `rega_we`=`regb_we`=`regs_we`=`dff_we`=1.
  - `rega_sel_cyc`=`regb_sel_cyc`=1 and `regs_sel_cyc`=0.
  - At `cnt`=15, go to READ.
- READ:
  - `regs_sel_cyc`=1, `out_valid`=1 and `out_data`=`add_sum`.
  - `out_last` = (`cnt`==15).
  - `regs_we` = `out_ready`, so S rotates only on a handshake.
  - When the `cnt`=15 word is accepted: load `out_carry` from `add_carry`, pulse `done`, and go to IDLE.
  - The adder holds S word 0 on `sum` at READ entry. Each `regs_we` rotate exposes the next word.
- All adder controls, `in_ready`, `out_valid` and `out_last` are combinational decodes of state, `cnt` and the handshake inputs. `add_datain` is a wire from `in_data`.
- `abort`:
  - Takes effect at the next edge: state goes to IDLE, `cnt` goes to 0, and no `done` pulse is generated.
  - Combinational enables deassert in the cycle after `abort` is sampled.
  - `out_carry` keeps its old value.
- `abort` and `start` high in the same cycle in IDLE: `abort` wins and the FSM stays in IDLE.
- `start` outside IDLE is ignored.
- Adder register contents are never assumed; every operation reloads A and B in full.

## Timing
- Reset values:
  - State is IDLE and `cnt` is 0.
  - `busy`, `done`, `out_carry`, `in_ready`, `out_valid` and `out_last` are 0.
  - All adder controls are 0.
- Reset mid-operation returns asynchronously to IDLE with the same values.
- With no stalls, `start` sampled at edge 0 gives:
  - LOAD_A in cycles 1-16.
  - LOAD_B in cycles 17-32.
  - CLR in cycle 33.
  - COMP in cycles 34-49.
  - READ in cycles 50-65.
  - `done` high in cycle 66.
- Minimum operation length is 65 busy cycles.
- `out_data` is combinational from the adder register. It must be stable while `out_valid`=1 and `out_ready`=0.

## Test plan
- Vector 1:
  - Stimulus: A=32C4AE2C_1F198119_5F990446_6A39C994_8FE30BBF_F2660BE1_715A4589_334C74C7, B=BC3736A2_F4F6779C_59BDCEE3_6B692153_D0A9877C_C62A4740_02DF32E5_2139F0A0, no stalls.
  - Required: 16 words equal to (A+B)[255:0] LSW first, first word 0x6567, `out_carry`=0, `done` in cycle 66.
- Vector 2:
  - Stimulus: A=8542D69E_4C044F18_E8B92435_BF6FF7DE_45728391_5C45517D_722EDB8B_08F1DFC3, B=987968B4_FA32C3FD_2417842E_73BBFEFF_2F3C848B_6831D7E0_EC65228B_3937E498, with random `in_valid` gaps and random `out_ready` deassertion.
  - Required: same word sequence as an unstalled run, first word 0xC45B, `out_carry`=1, no word duplicated or dropped.
- Carry ripple:
  - Stimulus: A=2^256-1, B=1.
  - Required: all 16 words 0x0000, `out_carry`=1. Run immediately after vector 2 to confirm CLR zeroes the stale carry.
- Abort mid-LOAD_B:
  - Stimulus: `abort` after 5 B words.
  - Required: IDLE at the next edge, `busy`=0, no `done`. A fresh vector 1 operation then produces correct results.
- Reset mid-COMP:
  - Stimulus: `rst_n` low during COMP.
  - Required: all outputs at their reset values immediately, IDLE on release.
- Start while busy:
  - Stimulus: `start` pulses during LOAD_A, COMP and READ.
  - Required: no state change and a correct result; a same-cycle `start`+`abort` in IDLE stays in IDLE.

Source files
------------

// File: rtl/uns_add_256_ctrl_if.sv
// Operand and sum streams between the host bus and the adder controller.
// Both directions use a valid/ready handshake, LSW first.
interface uns_add_256_ctrl_if;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic        out_last;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_last
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_last
  );
endinterface

// File: rtl/uns_add_256_ctrl.sv
// Sequencer for the word-serial 256-bit adder: load A, load B,
// clear carry, compute 16 words, then stream the sum out.
module uns_add_256_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        abort,
  uns_add_256_ctrl_if.slave strm,
  output logic        out_carry,
  output logic        busy,
  output logic        done,
  output logic [15:0] add_datain,
  output logic        rega_we,
  output logic        regb_we,
  output logic        dff_we,
  output logic        clr,
  output logic        regs_we,
  output logic        rega_sel_cyc,
  output logic        regb_sel_cyc,
  output logic        regs_sel_cyc,
  input  logic [15:0] add_sum,
  input  logic        add_carry
);

  typedef enum logic [2:0] {
    IDLE,
    LOAD_A,
    LOAD_B,
    CLR,
    COMP,
    READ
  } state_e;

  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       carry_q, carry_d;
  logic       done_q, done_d;
  logic       last_acc;
  logic       in_ready;
  logic       out_valid;
  logic       out_last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    in_ready     = 1'b0;
    out_valid    = 1'b0;
    out_last     = 1'b0;
    rega_we      = 1'b0;
    regb_we      = 1'b0;
    dff_we       = 1'b0;
    clr          = 1'b0;
    regs_we      = 1'b0;
    rega_sel_cyc = 1'b0;
    regb_sel_cyc = 1'b0;
    regs_sel_cyc = 1'b0;
    last_acc     = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (start) state_d = LOAD_A;
      end
      LOAD_A: begin
        in_ready = 1'b1;
        rega_we  = strm.in_valid;
        if (strm.in_valid) begin
          cnt_d = cnt_q + 4'd1;
          if (cnt_q == 4'd15) begin
            state_d = LOAD_B;
            cnt_d   = '0;
          end
        end
      end
      LOAD_B: begin
        in_ready = 1'b1;
        regb_we  = strm.in_valid;
        if (strm.in_valid) begin
          cnt_d = cnt_q + 4'd1;
          if (cnt_q == 4'd15) begin
            state_d = CLR;
            cnt_d   = '0;
          end
        end
      end
      CLR: begin
        clr     = 1'b1;
        state_d = COMP;
        cnt_d   = '0;
      end
      COMP: begin
        rega_we      = 1'b1;
        regb_we      = 1'b1;
        regs_we      = 1'b1;
        dff_we       = 1'b1;
        rega_sel_cyc = 1'b1;
        regb_sel_cyc = 1'b1;
        cnt_d        = cnt_q + 4'd1;
        if (cnt_q == 4'd15) begin
          state_d = READ;
          cnt_d   = '0;
        end
      end
      READ: begin
        // S recirculates so each accepted word exposes the next one
        regs_sel_cyc = 1'b1;
        out_valid    = 1'b1;
        out_last     = (cnt_q == 4'd15);
        regs_we      = strm.out_ready;
        if (strm.out_ready) begin
          cnt_d = cnt_q + 4'd1;
          if (cnt_q == 4'd15) begin
            state_d  = IDLE;
            cnt_d    = '0;
            last_acc = 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
    if (abort) begin
      state_d = IDLE;
      cnt_d   = '0;
    end
  end

  assign done_d  = last_acc & ~abort;
  assign carry_d = done_d ? add_carry : carry_q;

  assign strm.in_ready  = in_ready;
  assign strm.out_valid = out_valid;
  assign strm.out_last  = out_last;
  assign strm.out_data  = add_sum;

  assign add_datain = strm.in_data;
  assign out_carry  = carry_q;
  assign done       = done_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_uns_add_256_ctrl.sv
// Random-stall scoreboard bench for the adder sequencer, with a
// behavioural word-serial adder closing the loop.
module tb_uns_add_256_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start_drv = 1'b0;
  logic start_nz = 1'b0;
  logic abort = 1'b0;
  wire  start = start_drv | start_nz;

  logic        out_carry, busy, done;
  logic [15:0] add_datain, add_sum;
  logic        add_carry;
  logic        rega_we, regb_we, dff_we, clr, regs_we;
  logic        rega_sel_cyc, regb_sel_cyc, regs_sel_cyc;

  uns_add_256_ctrl_if bus ();

  uns_add_256_ctrl dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .abort        (abort),
    .strm         (bus.slave),
    .out_carry    (out_carry),
    .busy         (busy),
    .done         (done),
    .add_datain   (add_datain),
    .rega_we      (rega_we),
    .regb_we      (regb_we),
    .dff_we       (dff_we),
    .clr          (clr),
    .regs_we      (regs_we),
    .rega_sel_cyc (rega_sel_cyc),
    .regb_sel_cyc (regb_sel_cyc),
    .regs_sel_cyc (regs_sel_cyc),
    .add_sum      (add_sum),
    .add_carry    (add_carry)
  );

  always #5 clk = ~clk;

  // word-serial adder: shift toward index 0, new word enters at 15
  logic [15:0] ra [16];
  logic [15:0] rb [16];
  logic [15:0] rs [16];
  logic        rc = 1'b1;
  wire  [16:0] s17 = {1'b0, ra[0]} + {1'b0, rb[0]} + {16'b0, rc};

  initial begin
    for (int k = 0; k < 16; k++) begin
      ra[k] = 16'($urandom);
      rb[k] = 16'($urandom);
      rs[k] = 16'($urandom);
    end
  end

  always @(posedge clk) begin
    if (rega_we) begin
      for (int k = 0; k < 15; k++) ra[k] <= ra[k+1];
      ra[15] <= rega_sel_cyc ? ra[0] : add_datain;
    end
    if (regb_we) begin
      for (int k = 0; k < 15; k++) rb[k] <= rb[k+1];
      rb[15] <= regb_sel_cyc ? rb[0] : add_datain;
    end
    if (regs_we) begin
      for (int k = 0; k < 15; k++) rs[k] <= rs[k+1];
      rs[15] <= regs_sel_cyc ? rs[0] : s17[15:0];
    end
    if (clr) rc <= 1'b0;
    else if (dff_we) rc <= s17[16];
  end

  assign add_sum   = rs[0];
  assign add_carry = rc;

  int total = 0;
  int bad = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic [15:0] d;
    logic        last;
  } exp_t;

  exp_t wq[$];
  logic cq[$];

  bit   rdy_rand = 1'b0;
  bit   nz_en = 1'b0;
  bit   lat_chk = 1'b0;
  int   done_cnt = 0;
  logic last_carry = 1'b0;

  always @(posedge clk) begin
    #1;
    bus.out_ready = rdy_rand ? ($urandom_range(0, 2) != 0) : 1'b1;
    start_nz = nz_en && busy && ($urandom_range(0, 3) == 0);
  end

  exp_t        e;
  logic        hold_v = 1'b0;
  logic [15:0] hold_d = '0;
  logic        busy_p = 1'b0;
  logic        done_p = 1'b0;
  logic        ce;
  int          ncyc = 0;
  int          t_start = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      hold_v = 1'b0;
      busy_p = 1'b0;
      done_p = 1'b0;
    end else begin
      if (bus.out_valid && bus.out_ready) begin
        if (wq.size() == 0) begin
          total++;
          bad++;
          $display("FAIL extra_word: got %0h want none", bus.out_data);
        end else begin
          e = wq.pop_front();
          chk("sum_word", 32'(bus.out_data), 32'(e.d));
          chk("out_last", 32'(bus.out_last), 32'(e.last));
        end
      end
      if (hold_v && bus.out_valid)
        chk("hold_stable", 32'(bus.out_data), 32'(hold_d));
      hold_v = bus.out_valid && !bus.out_ready;
      hold_d = bus.out_data;
      if (busy && !busy_p) t_start = ncyc;
      if (done) begin
        done_cnt++;
        chk("done_single", 32'(done_p), 32'd0);
        if (cq.size() == 0) begin
          total++;
          bad++;
          $display("FAIL extra_done: got done want none");
        end else begin
          ce = cq.pop_front();
          last_carry = ce;
          chk("out_carry", 32'(out_carry), 32'(ce));
        end
        if (lat_chk) chk("done_latency", 32'(ncyc - t_start), 32'd65);
      end
      busy_p = busy;
      done_p = done;
      ncyc++;
    end
  end

  function automatic logic [7:0] ctrl_vec();
    return {rega_we, regb_we, regs_we, dff_we,
            rega_sel_cyc, regb_sel_cyc, regs_sel_cyc, clr};
  endfunction

  task automatic run_op(input logic [255:0] a, input logic [255:0] b,
                        input bit st_in, input int abort_at,
                        input bit rst_comp);
    logic [256:0] s;
    logic [15:0]  w [32];
    int           i;
    int           guard;
    int           n;
    logic         acc;
    exp_t         x;
    s = {1'b0, a} + {1'b0, b};
    for (int k = 0; k < 16; k++) begin
      w[k]    = a[16*k +: 16];
      w[16+k] = b[16*k +: 16];
    end
    if (abort_at < 0 && !rst_comp) begin
      for (int k = 0; k < 16; k++) begin
        x.d    = s[16*k +: 16];
        x.last = (k == 15);
        wq.push_back(x);
      end
      cq.push_back(s[256]);
    end
    n = done_cnt;
    @(posedge clk); #1;
    start_drv = 1'b1;
    @(posedge clk); #1;
    start_drv = 1'b0;
    i = 0;
    guard = 0;
    while (i < 32 && guard < 2000) begin
      if (i == abort_at) begin
        abort = 1'b1;
        bus.in_valid = 1'b0;
        @(posedge clk); #1;
        abort = 1'b0;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_in_ready", 32'(bus.in_ready), 32'd0);
        chk("abort_carry", 32'(out_carry), 32'(last_carry));
        repeat (4) @(posedge clk);
        #1;
        chk("abort_no_done", 32'(done_cnt), 32'(n));
        return;
      end
      bus.in_valid = st_in ? ($urandom_range(0, 2) != 0) : 1'b1;
      bus.in_data  = bus.in_valid ? w[i] : 16'($urandom);
      @(negedge clk);
      acc = bus.in_valid && bus.in_ready;
      @(posedge clk); #1;
      if (acc) i++;
      guard++;
    end
    bus.in_valid = 1'b0;
    if (i < 32) begin
      total++;
      bad++;
      $display("FAIL load_timeout: got %0d words want 32", i);
      return;
    end
    chk("clr_ctrl", 32'(ctrl_vec()), 32'h01);
    @(posedge clk); #1;
    chk("comp_ctrl", 32'(ctrl_vec()), 32'hFC);
    if (rst_comp) begin
      rst_n = 1'b0;
      #1;
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_carry", 32'(out_carry), 32'd0);
      chk("rst_hs", {29'd0, bus.in_ready, bus.out_valid, bus.out_last}, 32'd0);
      chk("rst_ctrl", 32'(ctrl_vec()), 32'h00);
      @(posedge clk); #1;
      rst_n = 1'b1;
      last_carry = 1'b0;
      @(posedge clk); #1;
      chk("rst_release_idle", 32'(busy), 32'd0);
      return;
    end
    guard = 0;
    while (done_cnt == n && guard < 3000) begin
      @(posedge clk);
      guard++;
    end
    if (done_cnt == n) begin
      total++;
      bad++;
      $display("FAIL done_timeout: got no done want done");
    end
    #1;
  endtask

  function automatic logic [255:0] rnd256();
    logic [255:0] r;
    for (int k = 0; k < 8; k++) r[32*k +: 32] = $urandom;
    return r;
  endfunction

  localparam logic [255:0] V1A =
    256'h32C4AE2C_1F198119_5F990446_6A39C994_8FE30BBF_F2660BE1_715A4589_334C74C7;
  localparam logic [255:0] V1B =
    256'hBC3736A2_F4F6779C_59BDCEE3_6B692153_D0A9877C_C62A4740_02DF32E5_2139F0A0;
  localparam logic [255:0] V2A =
    256'h8542D69E_4C044F18_E8B92435_BF6FF7DE_45728391_5C45517D_722EDB8B_08F1DFC3;
  localparam logic [255:0] V2B =
    256'h987968B4_FA32C3FD_2417842E_73BBFEFF_2F3C848B_6831D7E0_EC65228B_3937E498;
  localparam logic [255:0] ONES = '1;
  localparam logic [255:0] ONE  = 256'd1;

  initial begin
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_carry", 32'(out_carry), 32'd0);
    chk("reset_hs", {29'd0, bus.in_ready, bus.out_valid, bus.out_last}, 32'd0);
    chk("reset_ctrl", 32'(ctrl_vec()), 32'h00);
    rst_n = 1'b1;
    @(posedge clk); #1;

    lat_chk = 1'b1;
    run_op(V1A, V1B, 1'b0, -1, 1'b0);

    lat_chk = 1'b0;
    rdy_rand = 1'b1;
    run_op(V2A, V2B, 1'b1, -1, 1'b0);
    rdy_rand = 1'b0;

    lat_chk = 1'b1;
    run_op(ONES, ONE, 1'b0, -1, 1'b0);

    run_op(V1A, V1B, 1'b0, 21, 1'b0);
    run_op(V1A, V1B, 1'b0, -1, 1'b0);

    nz_en = 1'b1;
    run_op(V2A, V2B, 1'b0, -1, 1'b0);
    lat_chk = 1'b0;
    rdy_rand = 1'b1;
    for (int k = 0; k < 3; k++)
      run_op(rnd256(), rnd256(), 1'b1, -1, 1'b0);
    rdy_rand = 1'b0;
    nz_en = 1'b0;
    @(posedge clk); #1;

    start_drv = 1'b1;
    abort = 1'b1;
    @(posedge clk); #1;
    start_drv = 1'b0;
    abort = 1'b0;
    chk("start_abort_idle", 32'(busy), 32'd0);
    @(posedge clk); #1;
    chk("start_abort_stay", 32'(busy), 32'd0);

    run_op(V2A, V2B, 1'b0, -1, 1'b0);
    run_op(ONES, ONE, 1'b0, -1, 1'b1);
    lat_chk = 1'b1;
    run_op(V1A, V1B, 1'b0, -1, 1'b0);

    repeat (5) @(posedge clk);
    #1;
    chk("words_left", 32'(wq.size()), 32'd0);
    chk("carries_left", 32'(cq.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got hang want finish");
    $fatal(1);
  end

endmodule
